// File: rtl/avalon_mem_arbiter.sv
// Round-robin sharing of one Avalon-MM memory slave between two masters, one transaction per grant.
// The grant is registered one edge after a request, and the slave command follows in the next cycle. Masters stall on the slave's waitrequest, and any master without the grant stalls.
module avalon_mem_arbiter #(
  parameter int AW = 18,
  parameter int DW = 36
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [AW-1:0] s0_address,
  input  logic          s0_read,
  input  logic          s0_write,
  input  logic [DW-1:0] s0_writedata,
  output logic [DW-1:0] s0_readdata,
  output logic          s0_waitrequest,
  input  logic [AW-1:0] s1_address,
  input  logic          s1_read,
  input  logic          s1_write,
  input  logic [DW-1:0] s1_writedata,
  output logic [DW-1:0] s1_readdata,
  output logic          s1_waitrequest,
  output logic [AW-1:0] m_address,
  output logic          m_read,
  output logic          m_write,
  output logic [DW-1:0] m_writedata,
  input  logic [DW-1:0] m_readdata,
  input  logic          m_waitrequest,
  output logic [1:0]    o_grant
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          req0, req1;
  logic          sel_req, sel_read, sel_write;
  logic [AW-1:0] sel_address;
  logic [DW-1:0] sel_writedata;

  assign req0 = s0_read | s0_write;
  assign req1 = s1_read | s1_write;

  always_comb begin
    sel_address   = gnt_q ? s1_address   : s0_address;
    sel_writedata = gnt_q ? s1_writedata : s0_writedata;
    sel_read      = gnt_q ? s1_read      : s0_read;
    sel_write     = gnt_q ? s1_write     : s0_write;
    sel_req       = sel_read | sel_write;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = BUSY;
          // Under contention the master that did not go last wins.
          gnt_d   = (req0 & req1) ? ~last_q : req1;
        end
      end
      BUSY: begin
        if (!sel_req) begin
          state_d = IDLE;
        end else if (!m_waitrequest) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_address      = '0;
    m_writedata    = '0;
    m_read         = 1'b0;
    m_write        = 1'b0;
    o_grant        = 2'b00;
    s0_waitrequest = 1'b1;
    s1_waitrequest = 1'b1;
    s0_readdata    = '0;
    s1_readdata    = '0;
    if (state_q == BUSY) begin
      m_address   = sel_address;
      m_writedata = sel_writedata;
      m_write     = sel_write;
      // A simultaneous read and write is issued as a write only.
      m_read      = sel_read & ~sel_write;
      if (gnt_q) begin
        o_grant        = 2'b10;
        s1_waitrequest = m_waitrequest;
        s1_readdata    = m_readdata;
      end else begin
        o_grant        = 2'b01;
        s0_waitrequest = m_waitrequest;
        s0_readdata    = m_readdata;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Bench for avalon_mem_arbiter: directed scenarios, then random traffic from both masters
// checked cycle by cycle against a transaction-level model of grant order and routing.
module tb_avalon_mem_arbiter;
  localparam int AW = 18;
  localparam int DW = 36;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic [AW-1:0] s0_address, s1_address, m_address;
  logic          s0_read, s0_write, s1_read, s1_write;
  logic [DW-1:0] s0_writedata, s1_writedata, m_writedata;
  logic [DW-1:0] s0_readdata, s1_readdata, m_readdata;
  logic          s0_waitrequest, s1_waitrequest;
  logic          m_read, m_write, m_waitrequest;
  logic [1:0]    o_grant;

  int tests = 0;
  int fails = 0;

  avalon_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_readdata(s0_readdata), .s0_waitrequest(s0_waitrequest),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_readdata(s1_readdata), .s1_waitrequest(s1_waitrequest),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest), .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_masters();
    s0_read = 1'b0; s0_write = 1'b0; s0_address = '0; s0_writedata = '0;
    s1_read = 1'b0; s1_write = 1'b0; s1_address = '0; s1_writedata = '0;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    s0_read = 1'b1; s0_address = 18'o777;
    s1_write = 1'b1; s1_address = 18'o555;
    m_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge i_clk);
      tests++;
      if ({m_read, m_write, o_grant, s0_waitrequest, s1_waitrequest} !== 6'b000011) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got rd,wr,gnt,w0,w1=%b required 000011", i,
                 {m_read, m_write, o_grant, s0_waitrequest, s1_waitrequest});
      end
    end
    next_cycle();
    i_reset_n = 1'b1;
    idle_masters();
    m_waitrequest = 1'b1;
    @(negedge i_clk);
    tests++;
    if ({o_grant, m_address, s0_readdata} !== {2'b00, 18'd0, 36'd0}) begin
      fails++;
      $display("FAIL reset_idle_outputs: got gnt=%b addr=%o rdata=%o required 00/0/0",
               o_grant, m_address, s0_readdata);
    end
  endtask

  task automatic test_single_read();
    next_cycle();
    s0_read = 1'b1; s0_address = 18'o1000;
    m_waitrequest = 1'b1; m_readdata = '0;
    @(negedge i_clk);
    tests++;
    if ({o_grant, m_read, s0_waitrequest} !== 4'b0001) begin
      fails++;
      $display("FAIL sr_grant_cycle: got gnt,rd,w0=%b required 0001", {o_grant, m_read, s0_waitrequest});
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge i_clk);
      tests++;
      if ({o_grant, m_read, m_address, s0_waitrequest} !== {2'b01, 1'b1, 18'o1000, 1'b1}) begin
        fails++;
        $display("FAIL sr_wait[%0d]: got gnt=%b rd=%b addr=%o w0=%b required 01/1/1000/1",
                 i, o_grant, m_read, m_address, s0_waitrequest);
      end
    end
    next_cycle();
    m_waitrequest = 1'b0; m_readdata = 36'o123321456654;
    @(negedge i_clk);
    tests++;
    if ({s0_waitrequest, s0_readdata, s1_waitrequest, s1_readdata} !==
        {1'b0, 36'o123321456654, 1'b1, 36'd0}) begin
      fails++;
      $display("FAIL sr_complete: got w0=%b d0=%o w1=%b d1=%o required 0/123321456654/1/0",
               s0_waitrequest, s0_readdata, s1_waitrequest, s1_readdata);
    end
    next_cycle();
    s0_read = 1'b0; m_waitrequest = 1'b1; m_readdata = '0;
    @(negedge i_clk);
    tests++;
    if ({o_grant, m_read, m_address, s0_waitrequest} !== {2'b00, 1'b0, 18'd0, 1'b1}) begin
      fails++;
      $display("FAIL sr_back_to_idle: got gnt=%b rd=%b addr=%o w0=%b required 00/0/0/1",
               o_grant, m_read, m_address, s0_waitrequest);
    end
  endtask

  task automatic test_contention();
    next_cycle();
    i_reset_n = 1'b0;
    next_cycle();
    i_reset_n = 1'b1;
    s0_write = 1'b1; s0_address = 18'o100; s0_writedata = 36'o1;
    s1_write = 1'b1; s1_address = 18'o100; s1_writedata = 36'o2;
    m_waitrequest = 1'b0;
    for (int c = 0; c < 8; c++) begin
      logic [38:0] exp;
      if (c > 0) next_cycle();
      @(negedge i_clk);
      if (c % 2 == 0) exp = {2'b00, 1'b0, 36'd0};
      else if (c % 4 == 1) exp = {2'b01, 1'b1, 36'o1};
      else exp = {2'b10, 1'b1, 36'o2};
      tests++;
      if ({o_grant, m_write, m_writedata} !== exp) begin
        fails++;
        $display("FAIL contention[%0d]: got gnt=%b wr=%b wdata=%o required gnt=%b wr=%b wdata=%o",
                 c, o_grant, m_write, m_writedata, exp[38:37], exp[36], exp[35:0]);
      end
    end
  endtask

  task automatic test_read_write_both();
    next_cycle();
    s0_write = 1'b0;
    s1_read = 1'b1; s1_write = 1'b1; s1_address = 18'o42; s1_writedata = 36'o777;
    m_waitrequest = 1'b0;
    @(negedge i_clk);
    tests++;
    if ({o_grant, m_read, m_write} !== 4'b0000) begin
      fails++;
      $display("FAIL rw_gap: got gnt,rd,wr=%b required 0000", {o_grant, m_read, m_write});
    end
    next_cycle();
    @(negedge i_clk);
    tests++;
    if ({o_grant, m_write, m_read, m_address, m_writedata, s1_waitrequest} !==
        {2'b10, 1'b1, 1'b0, 18'o42, 36'o777, 1'b0}) begin
      fails++;
      $display("FAIL rw_as_write: got gnt=%b wr=%b rd=%b addr=%o wdata=%o w1=%b required 10/1/0/42/777/0",
               o_grant, m_write, m_read, m_address, m_writedata, s1_waitrequest);
    end
    next_cycle();
    idle_masters();
    @(negedge i_clk);
    tests++;
    if ({o_grant, m_write} !== 3'b000) begin
      fails++;
      $display("FAIL rw_idle_after: got gnt,wr=%b required 000", {o_grant, m_write});
    end
  endtask

  task automatic test_reset_mid_op();
    next_cycle();
    s1_read = 1'b1; s1_address = 18'o3333; m_waitrequest = 1'b1;
    next_cycle();
    @(negedge i_clk);
    tests++;
    if ({o_grant, m_read, s1_waitrequest} !== 4'b1011) begin
      fails++;
      $display("FAIL mid_granted: got gnt,rd,w1=%b required 1011", {o_grant, m_read, s1_waitrequest});
    end
    next_cycle();
    i_reset_n = 1'b0;
    @(negedge i_clk);
    tests++;
    if (s1_waitrequest !== 1'b1) begin
      fails++;
      $display("FAIL mid_stalled: got w1=%b required 1", s1_waitrequest);
    end
    next_cycle();
    i_reset_n = 1'b1;
    s0_read = 1'b1; s0_address = 18'o4444; m_waitrequest = 1'b0;
    @(negedge i_clk);
    tests++;
    if ({o_grant, m_read, s1_waitrequest, s0_waitrequest} !== 5'b00011) begin
      fails++;
      $display("FAIL mid_abandoned: got gnt,rd,w1,w0=%b required 00011",
               {o_grant, m_read, s1_waitrequest, s0_waitrequest});
    end
    next_cycle();
    @(negedge i_clk);
    tests++;
    if ({o_grant, m_read, m_address, s0_waitrequest, s1_waitrequest} !==
        {2'b01, 1'b1, 18'o4444, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL mid_m0_first: got gnt=%b rd=%b addr=%o w0=%b w1=%b required 01/1/4444/0/1",
               o_grant, m_read, m_address, s0_waitrequest, s1_waitrequest);
    end
    next_cycle();
    idle_masters();
    m_waitrequest = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_request_drop();
    next_cycle();
    s0_read = 1'b1; s0_address = 18'o1234; m_waitrequest = 1'b1;
    next_cycle();
    s1_read = 1'b1; s1_address = 18'o5670;
    @(negedge i_clk);
    tests++;
    if ({o_grant, m_read, m_address} !== {2'b01, 1'b1, 18'o1234}) begin
      fails++;
      $display("FAIL drop_m0_granted: got gnt=%b rd=%b addr=%o required 01/1/1234", o_grant, m_read, m_address);
    end
    next_cycle();
    s0_read = 1'b0;
    @(negedge i_clk);
    tests++;
    if ({o_grant, m_read, s0_waitrequest, s1_waitrequest} !== 5'b01011) begin
      fails++;
      $display("FAIL drop_cycle: got gnt,rd,w0,w1=%b required 01011",
               {o_grant, m_read, s0_waitrequest, s1_waitrequest});
    end
    next_cycle();
    @(negedge i_clk);
    tests++;
    if ({o_grant, m_read} !== 3'b000) begin
      fails++;
      $display("FAIL drop_idle: got gnt,rd=%b required 000", {o_grant, m_read});
    end
    next_cycle();
    @(negedge i_clk);
    tests++;
    if ({o_grant, m_read, m_address, s1_waitrequest} !== {2'b10, 1'b1, 18'o5670, 1'b1}) begin
      fails++;
      $display("FAIL drop_m1_next: got gnt=%b rd=%b addr=%o w1=%b required 10/1/5670/1",
               o_grant, m_read, m_address, s1_waitrequest);
    end
    next_cycle();
    idle_masters();
    @(negedge i_clk);
  endtask

  task automatic test_random();
    int            prev_owner, expo, last_srv;
    bit            prev_done, done, s_act;
    logic [1:0]    prev_req, cur_req;
    int unsigned   s_cnt, kind;
    logic          act[2], rd[2], wr[2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] dat[2];
    logic [AW-1:0] e_addr;
    logic          e_rd, e_wr;
    logic [DW-1:0] e_wd, e_srd0, e_srd1;
    logic [1:0]    e_gnt, e_swr;
    logic [131:0]  exp, obs;

    next_cycle();
    i_reset_n = 1'b0;
    idle_masters();
    m_waitrequest = 1'b1;
    prev_owner = -1; prev_done = 1'b0; prev_req = 2'b00; last_srv = 1;
    s_act = 1'b0; s_cnt = 0;
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; rd[m] = 1'b0; wr[m] = 1'b0; addr[m] = '0; dat[m] = '0;
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      i_reset_n = 1'b1;
      // Slot ownership follows from what was seen in the previous cycle.
      if (prev_owner >= 0) expo = prev_done ? -1 : prev_owner;
      else if (prev_req == 2'b11) expo = 1 - last_srv;
      else if (prev_req == 2'b01) expo = 0;
      else if (prev_req == 2'b10) expo = 1;
      else expo = -1;

      for (int m = 0; m < 2; m++) begin
        if (!act[m] && $urandom_range(0, 2) == 0) begin
          act[m]  = 1'b1;
          kind    = $urandom_range(1, 3);
          rd[m]   = kind[0];
          wr[m]   = kind[1];
          addr[m] = 18'($urandom());
          dat[m]  = {4'($urandom()), 32'($urandom())};
        end
      end
      cur_req = {act[1], act[0]};
      s0_read = act[0] & rd[0]; s0_write = act[0] & wr[0];
      s0_address   = act[0] ? addr[0] : 18'($urandom());
      s0_writedata = act[0] ? dat[0] : {4'($urandom()), 32'($urandom())};
      s1_read = act[1] & rd[1]; s1_write = act[1] & wr[1];
      s1_address   = act[1] ? addr[1] : 18'($urandom());
      s1_writedata = act[1] ? dat[1] : {4'($urandom()), 32'($urandom())};

      #1;
      if (m_read | m_write) begin
        if (!s_act) begin
          s_act = 1'b1;
          s_cnt = $urandom_range(0, 3);
        end
        m_waitrequest = (s_cnt != 0);
      end else begin
        s_act = 1'b0;
        m_waitrequest = 1'($urandom());
      end
      m_readdata = {4'($urandom()), 32'($urandom())};

      @(negedge i_clk);
      e_addr = '0; e_rd = 1'b0; e_wr = 1'b0; e_wd = '0;
      e_gnt = 2'b00; e_swr = 2'b11; e_srd0 = '0; e_srd1 = '0;
      if (expo == 0) begin
        e_addr = addr[0]; e_wr = wr[0]; e_rd = rd[0] & ~wr[0]; e_wd = dat[0];
        e_gnt = 2'b01; e_swr[0] = m_waitrequest; e_srd0 = m_readdata;
      end else if (expo == 1) begin
        e_addr = addr[1]; e_wr = wr[1]; e_rd = rd[1] & ~wr[1]; e_wd = dat[1];
        e_gnt = 2'b10; e_swr[1] = m_waitrequest; e_srd1 = m_readdata;
      end
      exp = {e_addr, e_rd, e_wr, e_wd, e_gnt, e_swr, e_srd0, e_srd1};
      obs = {m_address, m_read, m_write, m_writedata, o_grant,
             s1_waitrequest, s0_waitrequest, s0_readdata, s1_readdata};
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL random[%0d] owner=%0d: got %h required %h", cyc, expo, obs, exp);
      end

      done = (expo >= 0) && !m_waitrequest;
      if (done) begin
        if (expo == 0) act[0] = 1'b0;
        else act[1] = 1'b0;
        last_srv = expo;
      end
      if (s_act) begin
        if (s_cnt == 0) s_act = 1'b0;
        else s_cnt--;
      end
      prev_owner = expo;
      prev_done  = done;
      prev_req   = cur_req;
    end
    next_cycle();
    idle_masters();
    m_waitrequest = 1'b1;
  endtask

  initial begin
    i_reset_n = 1'b0;
    idle_masters();
    m_waitrequest = 1'b1;
    m_readdata = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_read_write_both();
    test_reset_mid_op();
    test_request_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
